// File: rtl/control_unit_if.sv
// control_unit_if: strobe bus between the hardwired control unit and the single-bus datapath
`timescale 1ns/1ps
interface control_unit_if;
   logic [31:0] IR;
   logic        CON;
   logic        Stop;
   logic        PCout, MARin, IncPC, Read, Write, MDRin, MDRout, IRin;
   logic        Gra, Grb, Grc, Rin, Rout, BAout;
   logic        Yin, Zin, Zlowout, Cout, HIout, LOout, PCin, CONin;
   logic [1:0]  ALUop;
   logic        Run;
   modport master (
      input  IR, CON, Stop,
      output PCout, MARin, IncPC, Read, Write, MDRin, MDRout, IRin,
      output Gra, Grb, Grc, Rin, Rout, BAout,
      output Yin, Zin, Zlowout, Cout, HIout, LOout, PCin, CONin,
      output ALUop, Run
   );
   modport slave (
      output IR, CON, Stop,
      input  PCout, MARin, IncPC, Read, Write, MDRin, MDRout, IRin,
      input  Gra, Grb, Grc, Rin, Rout, BAout,
      input  Yin, Zin, Zlowout, Cout, HIout, LOout, PCin, CONin,
      input  ALUop, Run
   );
endinterface

// File: rtl/control_unit.sv
// control_unit: Moore sequencer driving fetch, decode and execute strobes for the single-bus CPU datapath
`timescale 1ns/1ps
module control_unit (
   input logic            clk,
   input logic            clr,
   control_unit_if.master bus
);
   typedef enum logic [3:0] {RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALTED} state_t;
   localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010, OP_ADD = 5'b00011;
   localparam logic [4:0] OP_SUB = 5'b00100, OP_ADDI = 5'b01100, OP_BR = 5'b10010, OP_JR = 5'b10100;
   localparam logic [4:0] OP_MFHI = 5'b11000, OP_MFLO = 5'b11001, OP_HALT = 5'b11011;
   state_t     state, state_nxt, last;
   logic [4:0] op;
   logic       is_ld, is_ldi, is_st, is_add, is_sub, is_addi, is_br, is_jr, is_mfhi, is_mflo, is_halt;
   logic       alu3, imm, ldst;
   logic       unused_ir;
   assign unused_ir = ^bus.IR[26:0];
   assign is_ld   = op == OP_LD;
   assign is_ldi  = op == OP_LDI;
   assign is_st   = op == OP_ST;
   assign is_add  = op == OP_ADD;
   assign is_sub  = op == OP_SUB;
   assign is_addi = op == OP_ADDI;
   assign is_br   = op == OP_BR;
   assign is_jr   = op == OP_JR;
   assign is_mfhi = op == OP_MFHI;
   assign is_mflo = op == OP_MFLO;
   assign is_halt = op == OP_HALT;
   assign alu3    = is_add | is_sub | is_addi;
   assign ldst    = is_ld | is_st;
   assign imm     = is_ldi | ldst;
   assign last    = ldst ? T7 : is_br ? T6 : (alu3 | is_ldi) ? T5 : T3;
   // state register and opcode latch; clr aborts the instruction without waiting for an edge
   always_ff @(posedge clk or posedge clr)
      if (clr) begin
         state <= RESET;
         op    <= '0;
      end else begin
         state <= state_nxt;
         if (state == T2) op <= bus.IR[31:27];
      end
   // step sequencing: fetch is common, execute length depends on the latched opcode
   always_comb begin
      state_nxt = state;
      case (state)
         RESET:      state_nxt = T0;
         HALTED:     state_nxt = HALTED;
         T0, T1, T2: state_nxt = state_t'(state + 4'd1);
         default:    state_nxt = state != last ? state_t'(state + 4'd1) : (bus.Stop || is_halt) ? HALTED : T0;
      endcase
   end
   // strobe decode from the current step and latched opcode
   always_comb begin
      bus.PCout = 1'b0; bus.MARin = 1'b0; bus.IncPC = 1'b0; bus.Read = 1'b0;
      bus.Write = 1'b0; bus.MDRin = 1'b0; bus.MDRout = 1'b0; bus.IRin = 1'b0;
      bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0; bus.Rin = 1'b0; bus.Rout = 1'b0; bus.BAout = 1'b0;
      bus.Yin = 1'b0; bus.Zin = 1'b0; bus.Zlowout = 1'b0; bus.Cout = 1'b0;
      bus.HIout = 1'b0; bus.LOout = 1'b0; bus.PCin = 1'b0; bus.CONin = 1'b0;
      bus.ALUop = 2'b00;
      bus.Run = state inside {T0, T1, T2, T3, T4, T5, T6, T7};
      case (state)
         T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; end
         T1: begin bus.IncPC = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1; end
         T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
         T3: begin
            bus.Grb   = alu3 | imm;
            bus.BAout = imm;
            bus.Yin   = alu3 | imm;
            bus.Rout  = alu3 | is_br | is_jr;
            bus.Gra   = is_br | is_jr | is_mfhi | is_mflo;
            bus.CONin = is_br;
            bus.PCin  = is_jr;
            bus.HIout = is_mfhi;
            bus.LOout = is_mflo;
            bus.Rin   = is_mfhi | is_mflo;
         end
         T4: begin
            bus.Grc   = is_add | is_sub;
            bus.Rout  = is_add | is_sub;
            bus.Cout  = is_addi | imm;
            bus.Zin   = !is_br;
            bus.PCout = is_br;
            bus.Yin   = is_br;
            bus.ALUop = {1'b0, is_sub};
         end
         T5: begin
            bus.Zlowout = !is_br;
            bus.Gra     = !is_br && !ldst;
            bus.Rin     = !is_br && !ldst;
            bus.MARin   = ldst;
            bus.Cout    = is_br;
            bus.Zin     = is_br;
         end
         T6: begin
            bus.Read    = is_ld;
            bus.MDRin   = ldst;
            bus.Gra     = is_st;
            bus.Rout    = is_st;
            bus.Zlowout = is_br;
            bus.PCin    = is_br & bus.CON;
         end
         T7: begin
            bus.MDRout = is_ld;
            bus.Gra    = is_ld;
            bus.Rin    = is_ld;
            bus.Write  = is_st;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized instruction streams checked against a per-step strobe table through a scoreboard
`timescale 1ns/1ps
module tb_control_unit;
  typedef struct {
    logic [24:0] v;
    string       tag;
  } exp_t;
  typedef string sq_t[$];
  logic clk, clr;
  int   tests, fails;
  exp_t sb[$];
  string names [0:24] = '{"PCout", "MARin", "IncPC", "Read", "Write", "MDRin", "MDRout", "IRin",
                          "Gra", "Grb", "Grc", "Rin", "Rout", "BAout",
                          "Yin", "Zin", "Zlowout", "Cout", "HIout", "LOout", "PCin", "CONin",
                          "SUB", "ALU1", "Run"};
  logic [4:0] known [0:11] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd12, 5'd18, 5'd20, 5'd24, 5'd25, 5'd26, 5'd27};
  logic [24:0] act;
  control_unit_if bus ();
  control_unit dut (.clk(clk), .clr(clr), .bus(bus.master));
  assign act = {bus.Run, bus.ALUop, bus.CONin, bus.PCin, bus.LOout, bus.HIout, bus.Cout, bus.Zlowout,
                bus.Zin, bus.Yin, bus.BAout, bus.Rout, bus.Rin, bus.Grc, bus.Grb, bus.Gra, bus.IRin,
                bus.MDRout, bus.MDRin, bus.Write, bus.Read, bus.IncPC, bus.MARin, bus.PCout};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [24:0] enc(string s);
    logic [24:0] v = '0;
    int b = 0;
    for (int i = 0; i <= s.len(); i++)
      if (i == s.len() || s.getc(i) == 8'h20) begin
        if (i > b) begin
          string t = s.substr(b, i - 1);
          for (int j = 0; j < 25; j++) if (t == names[j]) v[j] = 1'b1;
        end
        b = i + 1;
      end
    return v;
  endfunction
  function automatic int len_of(logic [4:0] op);
    case (op)
      5'd0, 5'd2:              return 8;
      5'd18:                   return 7;
      5'd1, 5'd3, 5'd4, 5'd12: return 6;
      default:                 return 4;
    endcase
  endfunction
  function automatic string step_str(logic [4:0] op, int k, bit con);
    sq_t f, x;
    f = '{"PCout MARin", "IncPC Read MDRin", "MDRout IRin"};
    if (k < 3) return {f[k], " Run"};
    case (op)
      5'd0:  x = '{"Grb BAout Yin", "Cout Zin", "Zlowout MARin", "Read MDRin", "MDRout Gra Rin"};
      5'd1:  x = '{"Grb BAout Yin", "Cout Zin", "Zlowout Gra Rin"};
      5'd2:  x = '{"Grb BAout Yin", "Cout Zin", "Zlowout MARin", "Gra Rout MDRin", "Write"};
      5'd3:  x = '{"Grb Rout Yin", "Grc Rout Zin", "Zlowout Gra Rin"};
      5'd4:  x = '{"Grb Rout Yin", "Grc Rout Zin SUB", "Zlowout Gra Rin"};
      5'd12: x = '{"Grb Rout Yin", "Cout Zin", "Zlowout Gra Rin"};
      5'd18: x = '{"Gra Rout CONin", "PCout Yin", "Cout Zin", con ? "Zlowout PCin" : "Zlowout"};
      5'd20: x = '{"Gra Rout PCin"};
      5'd24: x = '{"HIout Gra Rin"};
      5'd25: x = '{"LOout Gra Rin"};
      default: x = '{""};
    endcase
    return {x[k - 3], " Run"};
  endfunction
  task automatic chk(logic [24:0] req, string tag);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b required %b", tag, act, req);
    end
  endtask
  task automatic push(logic [24:0] v, string tag);
    exp_t e;
    e.v = v;
    e.tag = tag;
    sb.push_back(e);
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    clr = 1'b1; bus.Stop = 1'($urandom); bus.IR = $urandom;
    push('0, "clr_asserted");
    #1 chk('0, "clr_async_reset_state");
    @(posedge clk); #1;
    clr = 1'b0; bus.Stop = 1'($urandom); bus.IR = $urandom;
    push('0, "reset_state");
  endtask
  task automatic run_instr(logic [31:0] ir, int stop_from, int abort_at, int con_mode);
    logic [4:0] op = ir[31:27];
    int n = len_of(op);
    bit aborted = 1'b0;
    for (int k = 0; k < n && !aborted; k++) begin
      if (k == abort_at) begin
        do_reset();
        aborted = 1'b1;
      end else begin
        bit con = con_mode == 2 ? 1'($urandom) : con_mode == 1;
        @(posedge clk); #1;
        bus.IR = k == 2 ? ir : $urandom;
        bus.CON = con;
        bus.Stop = stop_from >= 0 && k >= stop_from;
        push(enc(step_str(op, k, con)), $sformatf("op%02h_T%0d_con%0d", op, k, con));
      end
    end
    if (!aborted && (stop_from >= 0 || op == 5'd27)) begin
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #1;
        bus.IR = $urandom; bus.CON = 1'($urandom); bus.Stop = 1'($urandom);
        push('0, $sformatf("halted_after_op%02h_c%0d", op, c));
        #1 chk('0, $sformatf("halted_hold_op%02h_c%0d", op, c));
      end
      do_reset();
    end
    if (!aborted) bus.Stop = 1'b0;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk(e.v, e.tag);
    end
  end
  initial begin
    logic [4:0] op;
    int n;
    tests = 0; fails = 0;
    clr = 1'b1; bus.IR = '0; bus.CON = 1'b0; bus.Stop = 1'b0;
    do_reset();
    run_instr(32'hCB000000, -1, -1, 2);
    run_instr(32'h18000000, -1, -1, 2);
    run_instr(32'h20000000, -1, -1, 2);
    run_instr(32'h00000000, -1, -1, 2);
    run_instr(32'h10000000, -1, -1, 2);
    run_instr(32'h90000000, -1, -1, 1);
    run_instr(32'h90000000, -1, -1, 0);
    run_instr(32'h18000000, -1, 4, 2);
    run_instr(32'h60000000, -1, -1, 2);
    run_instr(32'hD0000000, 1, -1, 2);
    run_instr(32'hD8000000, -1, -1, 2);
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 9) < 7 ? known[$urandom_range(0, 11)] : 5'($urandom);
      n = len_of(op);
      run_instr({op, 27'($urandom)},
                $urandom_range(0, 19) == 0 ? $urandom_range(0, n - 1) : -1,
                $urandom_range(0, 24) == 0 ? $urandom_range(0, n - 1) : -1, 2);
    end
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/control_unit.md
# control_unit

Hardwired Moore control unit that sequences the CPU datapath, which has a single internal bus. It runs instruction fetch (T0–T2), decodes the IR opcode, and drives every per-cycle datapath strobe for the execute steps of the supported instruction subset. It replaces the hand-written state sequencing in the per-instruction testbenches. It sits beside the datapath and shares its clock.

## Interface
- Parameters: none.
- `clk` in 1: datapath clock; all state changes on the rising edge.
- `clr` in 1: reset, asynchronous, active-high. Forces state Reset and all outputs to 0.
- `IR` in 32: IR register contents. Opcode is `IR[31:27]`.
- `CON` in 1: branch-condition flip-flop output from the datapath.
- `Stop` in 1: external halt request.
- Fetch/memory outputs, each out 1: `PCout`, `MARin`, `IncPC`, `Read`, `Write`, `MDRin`, `MDRout`, `IRin`.
- Register-file outputs, each out 1: `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, `BAout`.
- ALU/bus outputs, each out 1: `Yin`, `Zin`, `Zlowout`, `Cout`, `HIout`, `LOout`, `PCin`, `CONin`.
- `ALUop` out 2: 00 = ADD, 01 = SUB; all other codes reserved.
- `Run` out 1: 1 while executing; 0 in Reset and Halted.

## Operation
- States: Reset, T0, T1, T2, T3, T4, T5, T6, T7, Halted.
- Outputs are a pure decode of (state, latched opcode, `CON`). Any strobe not listed for a step is 0.
- Opcode is latched into an internal 5-bit register on the edge that leaves T2.
- Decided opcode map:
  - ld 00000, ldi 00001, st 00010, add 00011, sub 00100, addi 01100
  - br 10010, jr 10100, mfhi 11000, mflo 11001, nop 11010, halt 11011
  - Any other opcode executes as nop.
- Fetch:
  - T0: PCout, MARin
  - T1: IncPC, Read, MDRin
  - T2: MDRout, IRin
- add/sub:
  - T3: Grb, Rout, Yin
  - T4: Grc, Rout, Zin, ALUop = ADD or SUB
  - T5: Zlowout, Gra, Rin
- addi: T3 Grb, Rout, Yin; T4 Cout, Zin, ALUop = ADD; T5 Zlowout, Gra, Rin.
- ldi: T3 Grb, BAout, Yin; T4 Cout, Zin, ALUop = ADD; T5 Zlowout, Gra, Rin.
- ld: T3–T4 as ldi; T5 Zlowout, MARin; T6 Read, MDRin; T7 MDRout, Gra, Rin.
- st: T3–T5 as ld; T6 Gra, Rout, MDRin (Read = 0); T7 Write.
- br: T3 Gra, Rout, CONin; T4 PCout, Yin; T5 Cout, Zin, ALUop = ADD; T6 Zlowout, PCin = CON.
- jr: T3 Gra, Rout, PCin.
- mfhi: T3 HIout, Gra, Rin. mflo: T3 LOout, Gra, Rin.
- nop and unknown opcodes: T3 has no strobes.
- halt: T3 has no strobes; next state is Halted.
- Transitions:
  - Reset → T0 on the first edge after `clr` deasserts.
  - Tn → Tn+1 through the instruction's last step. The last step → T0, or → Halted if `Stop` = 1 at that edge.
  - Halted is held until `clr`.
- `Run` = 1 in T0–T7.

## Timing
- One state per clock; every step lasts exactly one cycle.
- Instruction length, including fetch:
  - 4 cycles: mfhi, mflo, jr, nop, halt
  - 6 cycles: add, sub, addi, ldi
  - 7 cycles: br
  - 8 cycles: ld, st
- Memory is synchronous: data captured with Read/MDRin in a step is valid in MDR on the next step.
- `IR` must be stable from the T2→T3 edge onward. Decode uses only the latched opcode, so changes to `IR` after T3 have no effect.
- `CON` is sampled combinationally during br T6 only. It is not latched.
- `clr` asserted mid-instruction: state → Reset and outputs → 0 immediately, with no clock edge needed. No partial step completes after the assertion.
- `Stop` asserted mid-instruction: the current instruction completes, then → Halted. `Stop` is ignored in Reset and Halted.
- `clr` and `Stop` asserted together: `clr` wins.
- Outputs are glitch-free with respect to `IR`. `PCin` in br T6 may follow `CON` changes.

## Test plan
- Reset: assert `clr` mid-T4 of an add → outputs are all 0 and `Run` = 0 within 1 ns. Release `clr` → next edge enters T0 with PCout = MARin = 1.
- mflo R6 (`IR` = 0xCB000000 loaded in T2) → exactly 4 cycles. T3 has LOout = Gra = Rin = 1 and all other strobes 0, then returns to T0.
- add (`IR` = 0x18000000) → T4 has ALUop = 00, Zin = 1. sub (`IR` = 0x20000000) → T4 has ALUop = 01. Both return to T0 after T5.
- ld (`IR` = 0x00000000) → 8 cycles, T6 Read = MDRin = 1, T7 MDRout = Rin = 1. st (`IR` = 0x10000000) → T6 Read = 0, MDRin = 1; T7 Write = 1.
- br (`IR` = 0x90000000) with CON = 1 → PCin = 1 in T6. Same with CON = 0 → PCin = 0 throughout the instruction.
- halt (`IR` = 0xD8000000) → Halted after T3, `Run` = 0, and stays Halted for 10 cycles. `Stop` raised during T1 of a nop → Halted after that nop's T3.
